// File: rtl/mem_burst_slave.sv
// Paged burst memory slave on a multiplexed address/data bus: one ale cycle
// selects page, base address and direction, then BURST_LEN data beats follow.
module mem_burst_slave #(
    parameter logic [3:0]  PAGE_ID   = 4'h0,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 ale,
    input  logic                 rw,
    input  logic [DATAWIDTH-1:0] addr_data_in,
    output logic [DATAWIDTH-1:0] addr_data_out,
    output logic                 addr_data_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 burst_err
);

    localparam int unsigned     CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] base;
    logic [CNT_W-1:0]     cnt;
    logic [DATAWIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];

    logic                 page_hit;
    logic                 accept;
    logic                 last_beat;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;

    assign page_hit = (addr_data_in[15:12] == PAGE_ID);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ale && page_hit) begin
                    state_nxt = rw ? RD_BURST : WR_BURST;
                end
            end
            WR_BURST, RD_BURST: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The single memory port is addressed by the ale address in IDLE (read beat 0),
    // the current beat while writing, and the following beat while reading.
    always_comb begin
        busy      = (state != IDLE);
        accept    = (state == IDLE) && ale && page_hit;
        last_beat = busy && (cnt == LAST_CNT);
        mem_we    = (state == WR_BURST);
        mem_addr  = addr_data_in[ADDR_BITS-1:0];
        unique case (state)
            WR_BURST: mem_addr = base + ADDR_BITS'(cnt);
            RD_BURST: mem_addr = base + ADDR_BITS'(cnt) + ADDR_BITS'(1);
            default:  mem_addr = addr_data_in[ADDR_BITS-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            base          <= '0;
            cnt           <= '0;
            addr_data_out <= '0;
            addr_data_oe  <= 1'b0;
            done          <= 1'b0;
            burst_err     <= 1'b0;
        end else begin
            done <= last_beat;

            if (accept) begin
                base <= addr_data_in[ADDR_BITS-1:0];
                cnt  <= '0;
            end else if (last_beat) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept) begin
                addr_data_oe <= rw;
            end else if (last_beat) begin
                addr_data_oe <= 1'b0;
            end

            if ((accept && rw) || ((state == RD_BURST) && !last_beat)) begin
                addr_data_out <= mem[mem_addr];
            end

            if (busy && ale) begin
                burst_err <= 1'b1;
            end
        end
    end

    // No reset on the array: contents survive resetN.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= addr_data_in;
        end
    end

endmodule

// File: tb/tb_mem_burst_slave.sv
// Bench for mem_burst_slave: transaction-level timeline model checked every
// cycle, plus literal expectations on captured read beats and model memory.
module tb_mem_burst_slave;

    localparam int AB = 8;
    localparam int BL = 4;
    localparam int DW = 16;
    localparam int NW = 1 << AB;
    localparam logic [3:0] PAGE = 4'h0;

    logic          clk = 1'b0;
    logic          resetN = 1'b1;
    logic          ale = 1'b0;
    logic          rw = 1'b0;
    logic [DW-1:0] addr_data_in = '0;
    logic [DW-1:0] addr_data_out;
    logic          addr_data_oe;
    logic          busy;
    logic          done;
    logic          burst_err;

    mem_burst_slave #(
        .PAGE_ID  (PAGE),
        .ADDR_BITS(AB),
        .BURST_LEN(BL),
        .DATAWIDTH(DW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .ale          (ale),
        .rw           (rw),
        .addr_data_in (addr_data_in),
        .addr_data_out(addr_data_out),
        .addr_data_oe (addr_data_oe),
        .busy         (busy),
        .done         (done),
        .burst_err    (burst_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: a burst accepted at edge s is busy in cycles s..s+BL-1 and done in s+BL.
    logic [DW-1:0] mmem [NW];
    logic [DW-1:0] exp_rd [BL];
    int            m_start = -10;
    int            m_end = -10;
    int            m_base = 0;
    logic          m_wr = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] rd_q [$];

    function automatic logic [AB-1:0] widx(input int a);
        return AB'(a % NW);
    endfunction

    function automatic logic busy_at(input int c);
        return (c >= m_start) && (c <= m_end);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge resetN) begin
        m_start = -10;
        m_end   = -10;
        m_err   = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        if (!resetN) begin
            m_start = -10;
            m_end   = -10;
            m_err   = 1'b0;
        end else begin
            if (m_wr && cyc > m_start && cyc <= m_end + 1)
                mmem[widx(m_base + cyc - m_start - 1)] = addr_data_in;
            if (ale) begin
                if (busy_at(cyc - 1)) begin
                    m_err = 1'b1;
                end else if (addr_data_in[15:12] == PAGE) begin
                    m_start = cyc;
                    m_end   = cyc + BL - 1;
                    m_wr    = !rw;
                    m_base  = int'(addr_data_in[AB-1:0]);
                    if (rw)
                        for (int i = 0; i < BL; i++) exp_rd[i] = mmem[widx(m_base + i)];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!resetN) begin
                chk("rst_busy", busy, 0);
                chk("rst_oe", addr_data_oe, 0);
                chk("rst_done", done, 0);
                chk("rst_err", burst_err, 0);
                chk("rst_data", addr_data_out, 0);
            end else begin
                chk("busy", busy, busy_at(cyc));
                chk("oe", addr_data_oe, busy_at(cyc) && !m_wr);
                chk("done", done, cyc == m_end + 1);
                chk("burst_err", burst_err, m_err);
                if (busy_at(cyc) && !m_wr)
                    chk("rd_data", addr_data_out, exp_rd[cyc - m_start]);
                if (addr_data_oe) rd_q.push_back(addr_data_out);
            end
        end
    end

    task automatic bus(input logic a, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        ale = a;
        rw = r;
        addr_data_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, '0);
    endtask

    task automatic write_burst(input logic [DW-1:0] a, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic [DW-1:0] d3);
        bus(1'b1, 1'b0, a);
        bus(1'b0, 1'b0, d0);
        bus(1'b0, 1'b0, d1);
        bus(1'b0, 1'b0, d2);
        bus(1'b0, 1'b0, d3);
    endtask

    task automatic expect_reads(input string name, input logic [DW-1:0] e0,
                                input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                                input logic [DW-1:0] e3);
        logic [DW-1:0] e [4];
        e = '{e0, e1, e2, e3};
        if (rd_q.size() < 4) begin
            chk({name, "_beats"}, rd_q.size(), 4);
            rd_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) chk(name, rd_q.pop_front(), e[i]);
        end
    endtask

    initial begin
        #2 resetN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_oe", addr_data_oe, 0);
        chk("init_done", done, 0);
        chk("init_err", burst_err, 0);
        chk("init_data", addr_data_out, 0);
        @(negedge clk);
        resetN = 1'b1;

        // write then read back
        write_burst(16'h0010, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4);
        idle(2);
        bus(1'b1, 1'b1, 16'h0010);
        idle(6);
        expect_reads("wr_rd", 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4);

        // wrap-around inside the local space
        write_burst(16'h00FE, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        idle(2);
        chk("model_fe", mmem[8'hFE], 16'h0001);
        chk("model_ff", mmem[8'hFF], 16'h0002);
        chk("model_00", mmem[8'h00], 16'h0003);
        chk("model_01", mmem[8'h01], 16'h0004);
        bus(1'b1, 1'b1, 16'h00FE);
        idle(6);
        expect_reads("wrap", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

        // foreign page ignored
        bus(1'b1, 1'b1, 16'h1010);
        idle(6);
        chk("page_no_beats", rd_q.size(), 0);
        chk("page_no_err", burst_err, 0);

        // ale during beat 2 of a write is dropped and flagged
        bus(1'b1, 1'b0, 16'h0020);
        bus(1'b0, 1'b0, 16'hC1C1);
        bus(1'b1, 1'b1, 16'hC2C2);
        bus(1'b0, 1'b0, 16'hC3C3);
        bus(1'b0, 1'b0, 16'hC4C4);
        idle(2);
        chk("err_set", burst_err, 1);
        bus(1'b1, 1'b1, 16'h0020);
        idle(6);
        expect_reads("collide", 16'hC1C1, 16'hC2C2, 16'hC3C3, 16'hC4C4);
        chk("err_sticky", burst_err, 1);

        // back-to-back: each new ale lands in the previous burst's done cycle
        write_burst(16'h0030, 16'hD1D1, 16'hD2D2, 16'hD3D3, 16'hD4D4);
        bus(1'b1, 1'b1, 16'h0030);
        idle(4);
        bus(1'b1, 1'b1, 16'h0010);
        idle(6);
        expect_reads("b2b_1", 16'hD1D1, 16'hD2D2, 16'hD3D3, 16'hD4D4);
        expect_reads("b2b_2", 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA4A4);

        // reset after beat 2 of a write
        bus(1'b1, 1'b0, 16'h0010);
        bus(1'b0, 1'b0, 16'hB1B1);
        bus(1'b0, 1'b0, 16'hB2B2);
        @(negedge clk);
        resetN = 1'b0;
        ale = 1'b0;
        addr_data_in = 16'hB3B3;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_oe", addr_data_oe, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", burst_err, 0);
        chk("midrst_data", addr_data_out, 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        idle(1);
        chk("model_keep_12", mmem[8'h12], 16'hA3A3);
        bus(1'b1, 1'b1, 16'h0010);
        idle(6);
        expect_reads("rst_partial", 16'hB1B1, 16'hB2B2, 16'hA3A3, 16'hA4A4);
        chk("tail_empty", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_burst_slave.md
MEM_BURST_SLAVE -- requirements
Module: mem_burst_slave

Interface
REQ-001 SHALL have parameter PAGE_ID, default 4'h0, meaning the page (addr bits [15:12]) this slave answers.
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning the width of the local word address (memory depth 2**ADDR_BITS).
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning the number of data beats per transaction.
REQ-004 SHALL have parameter DATAWIDTH, default 16, meaning the bus and memory word width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  bus clock; all state changes on its rising edge.
REQ-007 resetN  input  1  asynchronous active-low reset.
REQ-008 ale  input  1  address-latch strobe from the master; high for one cycle with the address on addr_data_in.
REQ-009 rw  input  1  transaction type sampled with ale: 0 = WRITE, 1 = READ.
REQ-010 addr_data_in  input  DATAWIDTH  multiplexed bus in: {page[3:0], baseAddr[11:0]} on the ale cycle, write data on the beat cycles.
REQ-011 addr_data_out  output  DATAWIDTH  read data driven to the bus.
REQ-012 addr_data_oe  output  1  high while addr_data_out is a valid read beat.
REQ-013 busy  output  1  high while a burst is in progress.
REQ-014 done  output  1  one-cycle pulse in the cycle after the last beat of any burst.
REQ-015 burst_err  output  1  sticky flag: ale was seen while busy.

Function
REQ-016 SHALL implement the FSM states IDLE, WR_BURST and RD_BURST.
REQ-017 IDLE: at the edge where ale=1 and addr_data_in[15:12]==PAGE_ID, SHALL latch base = addr_data_in[ADDR_BITS-1:0] and clear the beat count to 0.
REQ-018 On that same edge, SHALL go to WR_BURST if rw=0 and to RD_BURST if rw=1.
REQ-019 IDLE with ale=1 and a page mismatch SHALL leave the block in IDLE with no output change.
REQ-020 Beat address SHALL be (base + cnt) mod 2**ADDR_BITS, so bursts wrap inside the local space; upper baseAddr bits above ADDR_BITS are ignored.
REQ-021 WR_BURST: at each of the BURST_LEN edges following the ale edge, SHALL write addr_data_in to mem[beat address] and increment cnt.
REQ-022 RD_BURST: at the ale edge, SHALL register mem[base] into addr_data_out and set addr_data_oe=1, so beat 0 is valid in the first cycle after ale.
REQ-023 RD_BURST: at each later edge, SHALL load the next beat, giving read latency 1 cycle and one beat per cycle for BURST_LEN cycles.
REQ-024 After the last beat (cnt==BURST_LEN-1 at an edge), SHALL return to IDLE, drop addr_data_oe, and pulse done=1 for exactly one cycle.
REQ-025 busy SHALL be 1 in every cycle the FSM is in WR_BURST or RD_BURST, and 0 in IDLE.
REQ-026 addr_data_out SHALL hold its last value when addr_data_oe=0; consumers ignore it.
REQ-027 ale=1 while busy SHALL NOT affect the current burst, SHALL be dropped, and SHALL set burst_err.
REQ-028 burst_err SHALL clear only on reset.
REQ-029 ale=1 in the same cycle done is high SHALL be accepted as a new transaction (back-to-back bursts, zero idle cycles).
REQ-030 The memory array SHALL have a single port; no read-during-write hazard exists because a burst is either all-write or all-read.

Reset
REQ-031 resetN=0 SHALL immediately force: state=IDLE, cnt=0, busy=0, done=0, addr_data_oe=0, addr_data_out=0, burst_err=0.
REQ-032 Reset mid-burst SHALL abort the burst; beats already written SHALL remain, and no further writes SHALL occur.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 After resetN deasserts, the first accepted ale SHALL be on a rising edge with resetN=1.

Verification
REQ-035 Write, then read: ale, rw=0, 16'h0010, then beats A1,A2,A3,A4; then ale, rw=1, 16'h0010 -> oe high for 4 cycles starting 1 cycle after ale, data A1..A4; done pulses once per burst.
REQ-036 Wrap-around: write at 16'h00FE, beats 1,2,3,4 -> mem[FE]=1, mem[FF]=2, mem[00]=3, mem[01]=4; read at 16'h00FE returns 1,2,3,4.
REQ-037 Page filter with PAGE_ID=0: ale, rw=1, 16'h1010 -> busy stays 0, oe stays 0, no done.
REQ-038 Collision: ale during beat 2 of a write -> burst completes unchanged, burst_err=1 and stays 1 until reset.
REQ-039 Back-to-back: a new read ale in the done cycle -> oe low for at most 1 cycle, then 4 new beats.
REQ-040 Reset mid-write: resetN low after beat 2 -> all outputs 0 at once; mem holds beats 1-2 only; a later read of those 4 addresses shows the old data in beats 3-4.
